// File: rtl/seq_branch_cmp.sv
// Multi-cycle MIPS branch comparator: scans operands MSB-first, SLICE bits per
// cycle, and reports equal / less / branch-condition with a start/busy/done handshake.
module seq_branch_cmp #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic             equal,
    output logic             less
);

    localparam int NS    = WIDTH / SLICE;
    localparam int CNT_W = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b010;
    localparam logic [2:0] OP_LTU = 3'b011;
    localparam logic [2:0] OP_LEZ = 3'b100;
    localparam logic [2:0] OP_GTZ = 3'b101;
    localparam logic [2:0] OP_LTZ = 3'b110;
    localparam logic [2:0] OP_GEZ = 3'b111;

    function automatic logic [SLICE-1:0] slice_at(input logic [WIDTH-1:0] v,
                                                  input logic [CNT_W-1:0] idx);
        logic [WIDTH-1:0] sh;
        int unsigned      base;
        base = int'(idx) * SLICE;
        sh   = v >> base;
        return sh[SLICE-1:0];
    endfunction

    function automatic logic branch_result(input logic [2:0] o,
                                           input logic       eq,
                                           input logic       lt);
        logic r;
        case (o)
            OP_EQ:   r = eq;
            OP_NE:   r = !eq;
            OP_LT:   r = lt;
            OP_LTU:  r = lt;
            OP_LEZ:  r = lt | eq;
            OP_GTZ:  r = !(lt | eq);
            OP_LTZ:  r = lt;
            OP_GEZ:  r = !lt;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             eq_acc_q, eq_acc_d;
    logic             lt_acc_q, lt_acc_d;
    logic             done_q, done_d;
    logic             result_q, result_d;
    logic             equal_q, equal_d;
    logic             less_q, less_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             load;
    logic [SLICE-1:0] sa, sb;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so the slice engine only ever needs an unsigned compare.
    always_comb begin
        a_d = d1;
        b_d = op[2] ? '0 : d2;
        if (op != OP_LTU) begin
            a_d[WIDTH-1] = ~a_d[WIDTH-1];
            b_d[WIDTH-1] = ~b_d[WIDTH-1];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        eq_acc_d = eq_acc_q;
        lt_acc_d = lt_acc_q;
        done_d   = 1'b0;
        result_d = result_q;
        equal_d  = equal_q;
        less_d   = less_q;
        load     = 1'b0;
        sa       = slice_at(a_q, cnt_q);
        sb       = slice_at(b_q, cnt_q);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    op_d     = op;
                    cnt_d    = CNT_LAST;
                    eq_acc_d = 1'b1;
                    lt_acc_d = 1'b0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // The first differing slice from the top decides the order.
                if (eq_acc_q && (sa != sb)) begin
                    eq_acc_d = 1'b0;
                    lt_acc_d = (sa < sb);
                end
                if (cnt_q == '0) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    equal_d  = eq_acc_d;
                    less_d   = lt_acc_d;
                    result_d = branch_result(op_q, eq_acc_d, lt_acc_d);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_EQ;
            eq_acc_q <= 1'b0;
            lt_acc_q <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 1'b0;
            equal_q  <= 1'b0;
            less_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            eq_acc_q <= eq_acc_d;
            lt_acc_q <= lt_acc_d;
            done_q   <= done_d;
            result_q <= result_d;
            equal_q  <= equal_d;
            less_q   <= less_d;
        end
    end

    // Operand registers are only read in RUN, after a load, so they need no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = done_q;
    assign result = result_q;
    assign equal  = equal_q;
    assign less   = less_q;

endmodule

// File: tb/tb_seq_branch_cmp.sv
// Scoreboarded random + directed bench for seq_branch_cmp (WIDTH=32, SLICE=8).
module tb_seq_branch_cmp;

    localparam int NS = 4;

    typedef struct {
        logic r;
        logic e;
        logic l;
        int   t;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] d1 = 32'd0;
    logic [31:0] d2 = 32'd0;
    logic        busy, done, result, equal, less;

    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    exp_t sbq[$];
    logic last_r = 1'b0, last_e = 1'b0, last_l = 1'b0;

    seq_branch_cmp #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .d1(d1), .d2(d2),
        .busy(busy), .done(done), .result(result), .equal(equal), .less(less)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t x;
        logic [31:0] bb;
        logic eq, lt;
        bb = o[2] ? 32'd0 : b;
        eq = (a == bb);
        lt = (o == 3'b011) ? (a < bb) : ($signed(a) < $signed(bb));
        case (o)
            3'd0: x.r = eq;
            3'd1: x.r = !eq;
            3'd2, 3'd3: x.r = lt;
            3'd4: x.r = lt | eq;
            3'd5: x.r = !(lt | eq);
            3'd6: x.r = lt;
            default: x.r = !lt;
        endcase
        x.e = eq;
        x.l = lt;
        x.t = 0;
        return x;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sbq.size() == 0) begin
                chk("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                exp_t x;
                x = sbq.pop_front();
                chk("result", {31'd0, result}, {31'd0, x.r});
                chk("equal", {31'd0, equal}, {31'd0, x.e});
                chk("less", {31'd0, less}, {31'd0, x.l});
                chk("latency", cyc - x.t, NS);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Called and returning at a falling edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t x;
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("wait_not_busy", {31'd0, busy}, 32'd0);
        x = model(o, a, b);
        x.t = cyc + 1;
        sbq.push_back(x);
        op = o; d1 = a; d2 = b; start = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("hold_on_start", {29'd0, result, equal, less}, {29'd0, last_r, last_e, last_l});
        last_r = x.r; last_e = x.e; last_l = x.l;
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom_range(0, 7));
        d1 = $urandom;
        d2 = $urandom;
    endtask

    initial begin
        #1;
        chk("rst_outs", {27'd0, busy, done, result, equal, less}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        issue(3'd0, 32'h12345678, 32'h12345678);
        issue(3'd2, 32'hFFFFFFFF, 32'h00000001);
        issue(3'd3, 32'hFFFFFFFF, 32'h00000001);
        issue(3'd1, 32'h00000001, 32'h00000000);
        issue(3'd0, 32'h00000001, 32'h00000000);
        issue(3'd5, 32'h80000000, 32'hDEADBEEF);
        issue(3'd4, 32'h00000000, 32'hDEADBEEF);
        issue(3'd7, 32'h00000000, 32'hDEADBEEF);
        issue(3'd6, 32'h7FFFFFFF, 32'hDEADBEEF);

        // A start pulse while busy must be ignored.
        issue(3'd0, 32'd5, 32'd5);
        @(negedge clk);
        op = 3'd1; d1 = 32'd1; d2 = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        issue(3'd3, 32'd3, 32'd4);

        // Reset mid-compare clears everything and no done follows.
        issue(3'd2, 32'h80000000, 32'h00000005);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_run", {27'd0, busy, done, result, equal, less}, 32'd0);
        sbq.delete();
        last_r = 1'b0; last_e = 1'b0; last_l = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_rst_quiet", {27'd0, busy, done, result, equal, less}, 32'd0);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a, b;
            logic [2:0]  o;
            int          mode;
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            mode = $urandom_range(0, 4);
            case (mode)
                1: b = a;
                2: b = a ^ (32'd1 << $urandom_range(0, 31));
                3: begin a = 32'($urandom_range(0, 3)); b = 32'($urandom_range(0, 3)); end
                4: begin a = {$urandom_range(0, 1) == 1, 31'd0}; b = 32'h7FFFFFFF; end
                default: ;
            endcase
            if (o[2] && mode == 1) a = 32'd0;
            issue(o, a, b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
        end

        begin
            int n = 0;
            while (sbq.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("drain", sbq.size(), 0);
        end
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
